mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mdu_divstep.sv | 26 ++
 rtl/mdu_unit.sv | 138 +++++++++++++
 tb/tb_mdu_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand widths, multiply/divide op codes, MDU state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Datapath and register-file geometry
  localparam int WIDTH     = 16;
  localparam int REG_IDX_W = 3;
  localparam int ITER_W    = 5;

  // Multiply/divide operation encodings; op[1] selects the divider
  localparam logic [1:0] MULLO = 2'b00;
  localparam logic [1:0] MULHI = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] REMU  = 2'b11;

  // MDU sequencer states
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] WB   = 2'b10;

  // True for the two divider operations
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module mdu_divstep #(
  parameter int WIDTH = cpu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Trial subtraction. rem_in is always below the divisor, so partial < 2*divisor and
  // the top bit of diff is set exactly when the subtraction borrows.
  always_comb begin
    partial = {rem_in, dividend_bit};
    diff    = partial - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit writing its result back to the register file.
// Latency: 17 cycles start-to-writeback (16 RUN + 1 WB); divide by zero writes back after 1 cycle.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module mdu_unit #(
  parameter int WIDTH = cpu_pkg::WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [WIDTH-1:0]              srca,
  input  logic [WIDTH-1:0]              srcb,
  input  logic [cpu_pkg::REG_IDX_W-1:0] dest,
  output logic                          busy,
  output logic                          write_en,
  output logic [cpu_pkg::REG_IDX_W-1:0] wreg,
  output logic [WIDTH-1:0]              writedata,
  output logic                          done
);

  import cpu_pkg::*;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  logic [1:0]           state;
  logic [ITER_W-1:0]    iter_cnt;

  // Operands captured at start
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [REG_IDX_W-1:0] dest_q;

  // Multiplier: upper half accumulates, lower half holds the not-yet-consumed multiplier bits
  logic [2*WIDTH-1:0]   product_q;
  // Divider: quotient register starts as the dividend and shifts quotient bits in at the bottom
  logic [WIDTH-1:0]     quotient_q;
  logic [WIDTH-1:0]     rem_q;

  logic [WIDTH:0]       prod_sum;
  logic [2*WIDTH-1:0]   product_nxt;
  logic [WIDTH-1:0]     quotient_nxt;
  logic [WIDTH-1:0]     rem_nxt;
  logic                 q_bit;
  logic [WIDTH-1:0]     result;
  logic                 div_by_zero;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in       (rem_q),
    .dividend_bit (quotient_q[WIDTH-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  // One shift-add multiply step and the result that the final RUN cycle writes back
  always_comb begin
    prod_sum     = {1'b0, product_q[2*WIDTH-1:WIDTH]}
                 + (product_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    product_nxt  = {prod_sum, product_q[WIDTH-1:1]};
    quotient_nxt = {quotient_q[WIDTH-2:0], q_bit};
    case (op_q)
      MULLO:   result = product_nxt[WIDTH-1:0];
      MULHI:   result = product_nxt[2*WIDTH-1:WIDTH];
      DIVU:    result = quotient_nxt;
      default: result = rem_nxt;
    endcase
  end

  // A zero divisor has a fixed answer, so it bypasses the iteration entirely
  always_comb begin
    div_by_zero = op_is_div(op) && (srcb == '0);
  end

  // Sequencer and datapath registers; reset aborts any operation before it can write back
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iter_cnt   <= '0;
      op_q       <= MULLO;
      mcand_q    <= '0;
      divisor_q  <= '0;
      dest_q     <= '0;
      product_q  <= '0;
      quotient_q <= '0;
      rem_q      <= '0;
      wreg       <= '0;
      writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            mcand_q    <= srca;
            divisor_q  <= srcb;
            dest_q     <= dest;
            iter_cnt   <= '0;
            product_q  <= {{WIDTH{1'b0}}, srcb};
            quotient_q <= srca;
            rem_q      <= '0;
            if (div_by_zero) begin
              state     <= WB;
              wreg      <= dest;
              writedata <= (op == DIVU) ? {WIDTH{1'b1}} : srca;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          product_q  <= product_nxt;
          quotient_q <= quotient_nxt;
          rem_q      <= rem_nxt;
          iter_cnt   <= iter_cnt + ITER_W'(1);
          if (iter_cnt == LAST_ITER) begin
            state     <= WB;
            wreg      <= dest_q;
            writedata <= result;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and strobes decode from state alone
  always_comb begin
    busy     = (state != IDLE);
    write_en = (state == WB);
    done     = (state == WB);
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit: hand-computed multiply/divide vectors, abort and ignore cases.
// Latency: checks writeback lands 16 cycles after the start edge (0 for divide by zero).
// Backpressure: exercises start asserted while busy.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] srca;
  logic [15:0] srcb;
  logic [2:0]  dest;
  logic        busy;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  mdu_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srca      (srca),
    .srcb      (srcb),
    .dest      (dest),
    .busy      (busy),
    .write_en  (write_en),
    .wreg      (wreg),
    .writedata (writedata),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (E0), returns at the negedge after E0
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    op    = o;
    srca  = a;
    srcb  = b;
    dest  = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for write_en, counting negedges since E0, then checks the writeback
  // and that the unit is idle with wreg/writedata held one cycle later.
  task automatic wait_wb(input string tag, input int n_start, input int exp_lat,
                         input logic [2:0] exp_reg, input logic [15:0] exp_dat);
    int n;
    n = n_start;
    while (!write_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".wreg"}, wreg, exp_reg);
    chk({tag, ".data"}, writedata, exp_dat);
    chk({tag, ".done"}, done, 1'b1);
    @(negedge clk);
    chk({tag, ".we_after"}, write_en, 1'b0);
    chk({tag, ".busy_after"}, busy, 1'b0);
    chk({tag, ".data_hold"}, writedata, exp_dat);
    chk({tag, ".wreg_hold"}, wreg, exp_reg);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    srca  = '0;
    srcb  = '0;
    dest  = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.write_en", write_en, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.wreg", wreg, 3'd0);
    chk("rst.writedata", writedata, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Idle with start low stays idle
    chk("idle.busy", busy, 1'b0);

    // 5 * 2 = 10
    issue(2'b00, 16'd5, 16'd2, 3'd3);
    chk("mullo.busy_run", busy, 1'b1);
    chk("mullo.we_run", write_en, 1'b0);
    wait_wb("mullo_5x2", 0, 16, 3'd3, 16'd10);

    // FFFF * FFFF = FFFE_0001
    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd1);
    wait_wb("mulhi_ffff", 0, 16, 3'd1, 16'hFFFE);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd2);
    wait_wb("mullo_ffff", 0, 16, 3'd2, 16'h0001);

    // 100 / 7 = 14 rem 2
    issue(2'b10, 16'd100, 16'd7, 3'd4);
    wait_wb("divu_100_7", 0, 16, 3'd4, 16'd14);
    issue(2'b11, 16'd100, 16'd7, 3'd5);
    wait_wb("remu_100_7", 0, 16, 3'd5, 16'd2);

    // Divide by zero writes back immediately
    issue(2'b10, 16'd1234, 16'd0, 3'd6);
    wait_wb("divu_by0", 0, 0, 3'd6, 16'hFFFF);
    issue(2'b11, 16'd9, 16'd0, 3'd7);
    wait_wb("remu_by0", 0, 0, 3'd7, 16'd9);

    // Register index 0 is written like any other
    issue(2'b10, 16'd60000, 16'd300, 3'd0);
    wait_wb("divu_dest0", 0, 16, 3'd0, 16'd200);

    // Second start at E5 during RUN is ignored
    issue(2'b00, 16'd6, 16'd7, 3'd5);
    repeat (4) @(negedge clk);
    op    = 2'b10;
    srca  = 16'd1000;
    srcb  = 16'd3;
    dest  = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_wb("ignore_start", 5, 16, 3'd5, 16'd42);

    // Reset at E8 aborts the operation
    issue(2'b00, 16'd1000, 16'd1000, 3'd6);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.busy", busy, 1'b0);
    chk("abort.write_en", write_en, 1'b0);
    chk("abort.wreg", wreg, 3'd0);
    chk("abort.writedata", writedata, 16'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_en) pulses++;
    end
    chk("abort.no_we", pulses, 0);
    issue(2'b00, 16'd3, 16'd4, 3'd2);
    wait_wb("after_abort_3x4", 0, 16, 3'd2, 16'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
